circ_queue: RTL

CIRC_QUEUE -- requirements
Module: circ_queue

---
 rtl/circ_queue.sv | 98 +++++++++
 1 files changed

// File: rtl/circ_queue.sv
// Circular-buffer queue with registered occupancy, almost-full level and sticky overflow/underflow flags.
// Define CIRC_QUEUE_BYPASS_EN to let a write into an empty queue fall through to o_rdata in the same cycle.
module circ_queue #(
  parameter int abits     = 6,
  parameter int dbits     = 128,
  parameter int afull_lvl = (1 << abits) - 1
) (
  input  logic             i_clk,
  input  logic             i_nrst,
  input  logic             i_flush,
  input  logic             i_we,
  input  logic [dbits-1:0] i_wdata,
  input  logic             i_re,
  output logic [dbits-1:0] o_rdata,
  output logic             o_nempty,
  output logic             o_full,
  output logic             o_afull,
  output logic [abits:0]   o_count,
  input  logic             i_clr_err,
  output logic             o_ovf,
  output logic             o_udf
);

  localparam int             DEPTH   = 1 << abits;
  localparam logic [abits:0] DEPTH_C = (abits+1)'(DEPTH);
  localparam logic [abits:0] AFULL_C = (abits+1)'(afull_lvl);

  logic [dbits-1:0] mem_q [DEPTH];
  logic [abits-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [abits:0]   count_q, count_d;
  logic             ovf_q, ovf_d, udf_q, udf_d;
  logic             stored, rd_acc, wr_acc, byp_take;

  always_comb begin
    stored = (count_q != '0);
`ifdef CIRC_QUEUE_BYPASS_EN
    // An empty queue presents the incoming word directly; a same-cycle read consumes it unstored.
    o_nempty = stored || i_we;
    o_rdata  = stored ? mem_q[rptr_q] : (i_we ? i_wdata : '0);
    byp_take = !stored && i_we && i_re;
`else
    o_nempty = stored;
    o_rdata  = stored ? mem_q[rptr_q] : '0;
    byp_take = 1'b0;
`endif
    rd_acc = i_re && stored;
    wr_acc = i_we && !byp_take && ((count_q != DEPTH_C) || rd_acc);

    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (i_flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (wr_acc) wptr_d = wptr_q + 1'b1;
      if (rd_acc) rptr_d = rptr_q + 1'b1;
      case ({wr_acc, rd_acc})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end

    // A fresh error event wins over a simultaneous clear; flush suppresses new events.
    ovf_d = (ovf_q && !i_clr_err) || (!i_flush && i_we && !wr_acc && !byp_take);
    udf_d = (udf_q && !i_clr_err) || (!i_flush && i_re && !o_nempty);
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge i_clk) begin
    if (wr_acc && !i_flush) mem_q[wptr_q] <= i_wdata;
  end

  assign o_full  = (count_q == DEPTH_C);
  assign o_afull = (count_q >= AFULL_C);
  assign o_count = count_q;
  assign o_ovf   = ovf_q;
  assign o_udf   = udf_q;

endmodule
